// File: rtl/cache_pkg.sv
// Shared types and block geometry for the cache miss/fill controller.
package cache_pkg;

  localparam int unsigned WORDS_PER_BLOCK   = 8;
  localparam int unsigned WORD_IDX_W        = 3;
  localparam int unsigned BLOCK_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

endpackage

// File: rtl/fill_counter.sv
// Latency and word counters for a block fill.
// word_tick marks the cycle in which the current word's data is sampled.
module fill_counter
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [WORD_IDX_W-1:0] word_cnt,
  output logic                  word_tick,
  output logic                  last_word
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [LAT_W-1:0] lat_cnt;

  assign word_tick = (lat_cnt == LAT_W'(MEM_LATENCY - 1));
  assign last_word = (word_cnt == WORD_IDX_W'(WORDS_PER_BLOCK - 1));

  // Hold each word address for MEM_LATENCY cycles, then step to the next word.
  // word_cnt wraps to 0 naturally when the last word is sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt  <= '0;
      word_cnt <= '0;
    end else if (clear) begin
      lat_cnt  <= '0;
      word_cnt <= '0;
    end else if (advance) begin
      if (word_tick) begin
        lat_cnt  <= '0;
        word_cnt <= word_cnt + 1'b1;
      end else begin
        lat_cnt <= lat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling controller: fills one 8-word block from a single-port
// memory and arbitrates write-through stores onto the same port.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  wt_req,
  input  logic [ADDR_WIDTH-1:0] wt_addr,
  input  logic [15:0]           wt_data,
  output logic                  wt_ack,
  output logic                  fill_busy,
  output logic                  fill_we,
  output logic [2:0]            fill_word_idx,
  output logic [15:0]           fill_data,
  output logic                  fill_tag_we,
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  output logic                  mem_enable,
  output logic                  mem_wr,
  input  logic [15:0]           mem_data_out
);

  fill_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic                  fill_start;
  logic                  advance;
  logic [WORD_IDX_W-1:0] word_cnt;
  logic                  word_tick;
  logic                  last_word;

  // Byte-offset bits within a block and the store's byte lane are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, miss_addr[BLOCK_OFFSET_BITS-1:0], wt_addr[0]};

  assign advance   = (state == ST_FILL);
  assign fill_data = mem_data_out;

  fill_counter #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_fill_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (fill_start),
    .advance   (advance),
    .word_cnt  (word_cnt),
    .word_tick (word_tick),
    .last_word (last_word)
  );

  // State register and block base captured on entry to FILL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      base  <= '0;
    end else begin
      state <= state_nxt;
      if (fill_start) begin
        base <= {miss_addr[ADDR_WIDTH-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
      end
    end
  end

  // Next-state and Moore output decode; stores win over fills in IDLE.
  always_comb begin
    state_nxt     = state;
    fill_start    = 1'b0;
    wt_ack        = 1'b0;
    fill_busy     = 1'b0;
    fill_we       = 1'b0;
    fill_word_idx = '0;
    fill_tag_we   = 1'b0;
    fill_done     = 1'b0;
    mem_addr      = '0;
    mem_data_in   = '0;
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wt_req) begin
          state_nxt = ST_WRITE;
        end else if (miss_req) begin
          state_nxt  = ST_FILL;
          fill_start = 1'b1;
        end
      end
      ST_WRITE: begin
        fill_busy   = 1'b1;
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = {wt_addr[ADDR_WIDTH-1:1], 1'b0};
        mem_data_in = wt_data;
        wt_ack      = 1'b1;
        state_nxt   = ST_IDLE;
      end
      ST_FILL: begin
        fill_busy     = 1'b1;
        mem_enable    = 1'b1;
        mem_addr      = base + ADDR_WIDTH'({word_cnt, 1'b0});
        fill_word_idx = word_cnt;
        if (word_tick) begin
          fill_we = 1'b1;
          if (last_word) begin
            fill_tag_we = 1'b1;
            state_nxt   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        fill_busy = 1'b1;
        fill_done = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: DUT A with MEM_LATENCY=1 gets
// directed and random traffic, DUT B with MEM_LATENCY=4 checks slow fills.
module tb_cache_fill_fsm;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] addr;
    logic [15:0] data;
    logic        tag;
    int          cyc;
  } fill_exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A (MEM_LATENCY = 1) ----------------
  logic        rst_a = 1'b0;
  logic        miss_req_a = 1'b0, wt_req_a = 1'b0;
  logic [15:0] miss_addr_a = '0, wt_addr_a = '0, wt_data_a = '0;
  logic        wt_ack_a, fill_busy_a, fill_we_a, fill_tag_we_a, fill_done_a;
  logic [2:0]  fill_word_idx_a;
  logic [15:0] fill_data_a, mem_addr_a, mem_data_in_a, mem_data_out_a;
  logic        mem_enable_a, mem_wr_a;
  logic [15:0] mem_a [0:32767];

  cache_fill_fsm #(.ADDR_WIDTH(16), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst_a), .miss_req(miss_req_a), .miss_addr(miss_addr_a),
    .wt_req(wt_req_a), .wt_addr(wt_addr_a), .wt_data(wt_data_a), .wt_ack(wt_ack_a),
    .fill_busy(fill_busy_a), .fill_we(fill_we_a), .fill_word_idx(fill_word_idx_a),
    .fill_data(fill_data_a), .fill_tag_we(fill_tag_we_a), .fill_done(fill_done_a),
    .mem_addr(mem_addr_a), .mem_data_in(mem_data_in_a), .mem_enable(mem_enable_a),
    .mem_wr(mem_wr_a), .mem_data_out(mem_data_out_a)
  );

  // ---------------- DUT B (MEM_LATENCY = 4) ----------------
  logic        rst_b = 1'b0;
  logic        miss_req_b = 1'b0, wt_req_b = 1'b0;
  logic [15:0] miss_addr_b = '0, wt_addr_b = '0, wt_data_b = '0;
  logic        wt_ack_b, fill_busy_b, fill_we_b, fill_tag_we_b, fill_done_b;
  logic [2:0]  fill_word_idx_b;
  logic [15:0] fill_data_b, mem_addr_b, mem_data_in_b, mem_data_out_b;
  logic        mem_enable_b, mem_wr_b;

  cache_fill_fsm #(.ADDR_WIDTH(16), .MEM_LATENCY(4)) dut_b (
    .clk(clk), .rst(rst_b), .miss_req(miss_req_b), .miss_addr(miss_addr_b),
    .wt_req(wt_req_b), .wt_addr(wt_addr_b), .wt_data(wt_data_b), .wt_ack(wt_ack_b),
    .fill_busy(fill_busy_b), .fill_we(fill_we_b), .fill_word_idx(fill_word_idx_b),
    .fill_data(fill_data_b), .fill_tag_we(fill_tag_we_b), .fill_done(fill_done_b),
    .mem_addr(mem_addr_b), .mem_data_in(mem_data_in_b), .mem_enable(mem_enable_b),
    .mem_wr(mem_wr_b), .mem_data_out(mem_data_out_b)
  );

  // Memory environment: A is writable and preloaded word=addr, B is read-only word=addr.
  initial for (int i = 0; i < 32768; i++) mem_a[i] = 16'(i * 2);
  always @(posedge clk) if (mem_enable_a && mem_wr_a) mem_a[mem_addr_a[15:1]] <= mem_data_in_a;
  assign mem_data_out_a = mem_a[mem_addr_a[15:1]];
  assign mem_data_out_b = {mem_addr_b[15:1], 1'b0};

  // ---------------- Reference model and scoreboard ----------------
  fill_exp_t   fq_a[$], fq_b[$];
  wr_exp_t     wq_a[$];
  logic [15:0] ref_w [int];
  logic [15:0] b_base = '0;
  int          b_t0 = 0;
  bit          b_active = 1'b0;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    int k;
    k = int'(a[15:1]);
    if (ref_w.exists(k)) return ref_w[k];
    return {a[15:1], 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Expected 8-word fill: word i of the block lands lat*(i+1) cycles after t0.
  task automatic push_fill(input logic [15:0] maddr, input int t0, input int lat, input bit to_b);
    fill_exp_t e;
    logic [15:0] base;
    base = {maddr[15:4], 4'h0};
    for (int i = 0; i < 8; i++) begin
      e.idx  = 3'(i);
      e.addr = base + 16'(2 * i);
      e.data = to_b ? {e.addr[15:1], 1'b0} : ref_rd(e.addr);
      e.tag  = (i == 7);
      e.cyc  = t0 + lat * (i + 1);
      if (to_b) fq_b.push_back(e);
      else      fq_a.push_back(e);
    end
  endtask

  task automatic push_wr(input logic [15:0] waddr, input logic [15:0] wdata, input int c);
    wr_exp_t w;
    w.addr = {waddr[15:1], 1'b0};
    w.data = wdata;
    w.cyc  = c;
    wq_a.push_back(w);
    ref_w[int'(waddr[15:1])] = wdata;
  endtask

  fill_exp_t mon_fa, mon_fb;
  wr_exp_t   mon_wa;

  // Monitor A: pop and compare whenever the DUT presents a fill word or a store ack.
  always @(negedge clk) begin
    if (rst_a) begin
      if (fill_we_a) begin
        if (fq_a.size() == 0) fail_now("A fill_we with no fill expected");
        else begin
          mon_fa = fq_a.pop_front();
          chk("A fill_word_idx", 32'(fill_word_idx_a), 32'(mon_fa.idx));
          chk("A fill_data", 32'(fill_data_a), 32'(mon_fa.data));
          chk("A fill mem_addr", 32'(mem_addr_a), 32'(mon_fa.addr));
          chk("A fill_tag_we", 32'(fill_tag_we_a), 32'(mon_fa.tag));
          chk("A fill_we cycle", 32'(cyc), 32'(mon_fa.cyc));
        end
      end else if (fill_tag_we_a) begin
        chk("A fill_tag_we without fill_we", 32'(fill_tag_we_a), 32'd0);
      end
      if (wt_ack_a) begin
        if (wq_a.size() == 0) fail_now("A wt_ack with no store expected");
        else begin
          mon_wa = wq_a.pop_front();
          chk("A store mem_addr", 32'(mem_addr_a), 32'(mon_wa.addr));
          chk("A store mem_data_in", 32'(mem_data_in_a), 32'(mon_wa.data));
          chk("A store mem_wr", 32'(mem_wr_a & mem_enable_a), 32'd1);
          chk("A wt_ack cycle", 32'(cyc), 32'(mon_wa.cyc));
        end
      end
      if (mem_wr_a) chk("A mem_wr only with wt_ack", 32'(wt_ack_a), 32'd1);
      if (mem_enable_a) chk("A mem_addr bit0", 32'(mem_addr_a[0]), 32'd0);
    end
  end

  // Monitor B: fill words plus the per-word address hold of 4 cycles.
  always @(negedge clk) begin
    if (rst_b) begin
      if (fill_we_b) begin
        if (fq_b.size() == 0) fail_now("B fill_we with no fill expected");
        else begin
          mon_fb = fq_b.pop_front();
          chk("B fill_word_idx", 32'(fill_word_idx_b), 32'(mon_fb.idx));
          chk("B fill_data", 32'(fill_data_b), 32'(mon_fb.data));
          chk("B fill_tag_we", 32'(fill_tag_we_b), 32'(mon_fb.tag));
          chk("B fill_we cycle", 32'(cyc), 32'(mon_fb.cyc));
        end
      end
      if (mem_enable_b) begin
        if (!b_active) fail_now("B mem_enable outside a fill");
        else chk("B mem_addr hold", 32'(mem_addr_b),
                 32'(b_base + 16'(2 * ((cyc - b_t0 - 1) / 4))));
        chk("B mem_wr during fill", 32'(mem_wr_b), 32'd0);
      end
    end
  end

  // ---------------- Driver helpers (DUT A) ----------------
  task automatic wait_a(input bit want_ack, input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (want_ack ? wt_ack_a : fill_done_a) begin
        c = cyc;
        break;
      end
      // Base is captured by now; wiggling miss_addr must not disturb the fill.
      if (fill_busy_a && !wt_ack_a && miss_req_a) miss_addr_a = 16'($urandom);
    end
    if (c < 0) fail_now(want_ack ? "A timeout waiting for wt_ack" : "A timeout waiting for fill_done");
  endtask

  task automatic chk_idle_a(input string nm);
    chk({nm, " outputs"}, {22'd0, wt_ack_a, fill_busy_a, fill_we_a, fill_tag_we_a,
        fill_done_a, mem_enable_a, mem_wr_a, fill_word_idx_a}, 32'd0);
    chk({nm, " mem_addr/data_in"}, {mem_addr_a, mem_data_in_a}, 32'd0);
  endtask

  task automatic do_fill(input logic [15:0] maddr);
    int s, c;
    @(negedge clk);
    s = cyc;
    push_fill(maddr, s, 1, 1'b0);
    miss_req_a = 1'b1;
    miss_addr_a = maddr;
    wait_a(1'b0, 40, c);
    if (c >= 0) chk("A fill_done cycle", 32'(c - s), 32'd9);
    miss_req_a = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] waddr, input logic [15:0] wdata);
    int s, c;
    @(negedge clk);
    s = cyc;
    push_wr(waddr, wdata, s + 1);
    wt_req_a = 1'b1;
    wt_addr_a = waddr;
    wt_data_a = wdata;
    wait_a(1'b1, 10, c);
    wt_req_a = 1'b0;
  endtask

  task automatic do_both(input logic [15:0] waddr, input logic [15:0] wdata, input logic [15:0] maddr);
    int s, c;
    @(negedge clk);
    s = cyc;
    push_wr(waddr, wdata, s + 1);
    push_fill(maddr, s + 2, 1, 1'b0);
    wt_req_a = 1'b1; wt_addr_a = waddr; wt_data_a = wdata;
    miss_req_a = 1'b1; miss_addr_a = maddr;
    wait_a(1'b1, 10, c);
    wt_req_a = 1'b0;
    wait_a(1'b0, 40, c);
    if (c >= 0) chk("A fill_done cycle after store", 32'(c - s), 32'd11);
    miss_req_a = 1'b0;
  endtask

  task automatic do_fill_wt(input logic [15:0] maddr, input logic [15:0] waddr, input logic [15:0] wdata);
    int s, c;
    @(negedge clk);
    s = cyc;
    push_fill(maddr, s, 1, 1'b0);
    miss_req_a = 1'b1; miss_addr_a = maddr;
    repeat (3) @(negedge clk);
    push_wr(waddr, wdata, s + 11);
    wt_req_a = 1'b1; wt_addr_a = waddr; wt_data_a = wdata;
    wait_a(1'b0, 40, c);
    if (c >= 0) chk("A fill_done with pending store", 32'(c - s), 32'd9);
    miss_req_a = 1'b0;
    wait_a(1'b1, 10, c);
    if (c >= 0) chk("A deferred wt_ack cycle", 32'(c - s), 32'd11);
    wt_req_a = 1'b0;
  endtask

  task automatic do_fill_reset(input logic [15:0] maddr);
    int s;
    @(negedge clk);
    s = cyc;
    push_fill(maddr, s, 1, 1'b0);
    miss_req_a = 1'b1; miss_addr_a = maddr;
    while (cyc != s + 4) @(negedge clk);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    miss_req_a = 1'b0;
    #1;
    chk_idle_a("A async reset mid-fill");
    chk("A words left unfilled at reset", 32'(fq_a.size()), 32'd4);
    fq_a.delete();
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    logic [15:0] a, w, d;
    int op, c, s;
    #1;
    chk_idle_a("A in reset");
    chk("B in reset", {27'd0, fill_busy_b, fill_we_b, mem_enable_b, mem_wr_b, fill_done_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle_a("A idle after reset");
    end

    do_fill(16'h1236);
    do_both(16'h1234, 16'hBEEF, 16'h1230);
    do_fill_reset(16'h1230);
    do_fill(16'h1230);
    do_fill_wt(16'h2000, 16'h2004, 16'h5A5A);
    do_fill(16'h2000);
    do_write(16'h3001, 16'h1111);
    do_write(16'h3003, 16'h2222);
    do_fill(16'h300F);

    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 3);
      a  = 16'h1200 | 16'($urandom_range(0, 255));
      w  = 16'h1200 | 16'($urandom_range(0, 255));
      d  = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case (op)
        0: do_write(w, d);
        1: do_fill(a);
        2: do_both(w, d, a);
        default: do_fill_wt(a, w, d);
      endcase
    end

    // DUT B: slow memory, block 0x0000 and one random block.
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 16'h0000 : 16'($urandom);
      @(negedge clk);
      s = cyc;
      b_t0 = s;
      b_base = {a[15:4], 4'h0};
      b_active = 1'b1;
      push_fill(a, s, 4, 1'b1);
      miss_req_b = 1'b1;
      miss_addr_b = a;
      c = -1;
      for (int j = 0; j < 60; j++) begin
        @(negedge clk);
        if (fill_done_b) begin
          c = cyc;
          break;
        end
      end
      if (c < 0) fail_now("B timeout waiting for fill_done");
      else chk("B fill_done cycle", 32'(c - s), 32'd33);
      miss_req_b = 1'b0;
      @(negedge clk);
      b_active = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk_idle_a("A idle at end");
    chk("A fill queue drained", 32'(fq_a.size()), 32'd0);
    chk("A store queue drained", 32'(wq_a.size()), 32'd0);
    chk("B fill queue drained", 32'(fq_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
